seq_enable_lanes_pipe: RTL and testbench



---
 rtl/seq_enable_pkg.sv | 48 ++++
 rtl/seq_enable_stage.sv | 51 +++++
 rtl/seq_enable_lanes_pipe.sv | 108 ++++++++++
 tb/tb_seq_enable_lanes_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_enable_pkg.sv
// ---------------------------------------------------------------------------
// seq_enable_pkg
//   Shared constants and lane helpers for the lane-masked enable pipeline.
//   - DEF_* : default geometry of the pipeline
//   - DEF_RESET_BIT : fill bit of the default reset/clear word
//   - lane_lo / lane_hi / word_w : lane index and width arithmetic
//   - lane(word, i, lane_w) : extract lane i of a word. Words are passed
//     zero-extended to MAX_WORD_W bits, and the result is right-aligned in
//     MAX_LANE_W bits. The caller truncates the result to its own lane width.
// ---------------------------------------------------------------------------
package seq_enable_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_DEPTH  = 2;

  // Upper bounds for the generic lane helper.
  localparam int MAX_WORD_W = 1024;
  localparam int MAX_LANE_W = 256;

  // The default reset/clear word is all copies of this bit. Expressing it as
  // a single bit lets it fit any LANES*LANE_W geometry.
  localparam logic DEF_RESET_BIT = 1'b0;

  function automatic int word_w(input int lanes, input int lane_w);
    return lanes * lane_w;
  endfunction

  function automatic int lane_lo(input int i, input int lane_w);
    return i * lane_w;
  endfunction

  function automatic int lane_hi(input int i, input int lane_w);
    return (i + 1) * lane_w - 1;
  endfunction

  function automatic logic [MAX_LANE_W-1:0] lane(
    input logic [MAX_WORD_W-1:0] word,
    input int                    i,
    input int                    lane_w
  );
    logic [MAX_LANE_W-1:0] m;
    m = '1;
    m = m >> (MAX_LANE_W - lane_w);
    return MAX_LANE_W'(word >> lane_lo(i, lane_w)) & m;
  endfunction

endpackage

// File: rtl/seq_enable_stage.sv
// ---------------------------------------------------------------------------
// seq_enable_stage
//   One pipeline stage: a data register and a valid flag.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset (dat <- RESET_VAL, vld <- 0)
//     clr       synchronous clear, same effect as reset, overrides loads
//     load_vld  stage advances this cycle: vld takes nxt_vld
//     load_dat  a valid word arrives this cycle: dat takes nxt_dat
//     nxt_dat   incoming word
//     nxt_vld   incoming valid flag
//     dat       held word
//     vld       held valid flag
//   The data and valid loads are separate so that a bubble passing through
//   clears vld but leaves the previously held word in place.
// ---------------------------------------------------------------------------
module seq_enable_stage
  import seq_enable_pkg::*;
#(
  parameter int           W         = DEF_LANES * DEF_LANE_W,
  parameter logic [W-1:0] RESET_VAL = {W{DEF_RESET_BIT}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load_vld,
  input  logic         load_dat,
  input  logic [W-1:0] nxt_dat,
  input  logic         nxt_vld,
  output logic [W-1:0] dat,
  output logic         vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat <= RESET_VAL;
      vld <= 1'b0;
    end else if (clr) begin
      dat <= RESET_VAL;
      vld <= 1'b0;
    end else begin
      if (load_vld) begin
        vld <= nxt_vld;
      end
      if (load_dat) begin
        dat <= nxt_dat;
      end
    end
  end

endmodule

// File: rtl/seq_enable_lanes_pipe.sv
// ---------------------------------------------------------------------------
// seq_enable_lanes_pipe
//   Enabled-register pipeline with per-lane write masks and valid/ready flow
//   control. Stage 0 merges each accepted beat into the last accepted word,
//   lane by lane. The merged word then moves through DEPTH-1 further stages
//   with bubble collapsing and backpressure.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     clr        synchronous clear; overrides every transfer
//     in_valid   producer beat valid
//     in_ready   pipeline accepts a beat this cycle (combinational)
//     in_mask    per-lane write enable, bit i selects lane i of in_data
//     in_data    lane i = bits [i*LANE_W +: LANE_W]
//     out_valid  q holds a valid word
//     out_ready  consumer accepts q
//     q          last-stage word
// ---------------------------------------------------------------------------
module seq_enable_lanes_pipe
  import seq_enable_pkg::*;
#(
  parameter int                       LANES     = DEF_LANES,
  parameter int                       LANE_W    = DEF_LANE_W,
  parameter int                       DEPTH     = DEF_DEPTH,
  parameter logic [LANES*LANE_W-1:0]  RESET_VAL = {(LANES*LANE_W){DEF_RESET_BIT}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] q
);

  localparam int W = LANES * LANE_W;

  logic [W-1:0]     dat      [DEPTH];
  logic [W-1:0]     nxt_dat  [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] nxt_vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load_dat;
  logic [W-1:0]     merged;
  logic             accept;

  // Stage k may advance when any stage from k to the output is empty, or
  // the consumer pops. This is the unrolled form of
  // adv[k] = !vld[k] | adv[k+1], written flat so that no bit of adv depends
  // on another.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_adv
      assign adv[gi] = out_ready | ~(&vld[DEPTH-1:gi]);
    end
  endgenerate

  assign in_ready = adv[0] & ~clr;
  assign accept   = in_valid & in_ready;

  // Lane merge: masked-off lanes keep the last accepted word held in stage 0.
  // The merged word is only loaded on accept, so the held word is the merge
  // base even after a bubble.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_merge
      assign merged[gi*LANE_W +: LANE_W] = in_mask[gi]
        ? LANE_W'(lane(MAX_WORD_W'(in_data),  gi, LANE_W))
        : LANE_W'(lane(MAX_WORD_W'(dat[0]),   gi, LANE_W));
    end
  endgenerate

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign nxt_dat[gi]  = merged;
        assign nxt_vld[gi]  = accept;
        assign load_dat[gi] = accept;
      end else begin : g_tail
        assign nxt_dat[gi]  = dat[gi-1];
        assign nxt_vld[gi]  = vld[gi-1];
        // A bubble moving in only clears vld; the held word stays.
        assign load_dat[gi] = adv[gi] & vld[gi-1];
      end

      seq_enable_stage #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load_vld (adv[gi]),
        .load_dat (load_dat[gi]),
        .nxt_dat  (nxt_dat[gi]),
        .nxt_vld  (nxt_vld[gi]),
        .dat      (dat[gi]),
        .vld      (vld[gi])
      );
    end
  endgenerate

  assign q         = dat[DEPTH-1];
  assign out_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_seq_enable_lanes_pipe.sv
// ---------------------------------------------------------------------------
// tb_seq_enable_lanes_pipe
//   Self-checking bench for seq_enable_lanes_pipe (LANES=4, LANE_W=8, DEPTH=2,
//   RESET_VAL=A5A5A5A5). A reference model keeps the beats in flight as a
//   queue of (word, stage position) pairs. Each beat advances one stage per
//   cycle unless the beat ahead of it blocks it. Directed scenarios are
//   followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_seq_enable_lanes_pipe;

  localparam int          LANES  = 4;
  localparam int          LANE_W = 8;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RV     = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mask;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;

  seq_enable_lanes_pipe #(
    .LANES     (LANES),
    .LANE_W    (LANE_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] wq[$];     // words in flight, oldest first
  int          pq[$];     // stage position of each word in flight
  logic [31:0] base_m;    // last accepted word (merge base)
  logic [31:0] q_m;       // word currently held by the last stage

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;
  int   acc_cnt = 0;
  logic rdy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    pq.delete();
    base_m = RV;
    q_m    = RV;
  endtask

  // One clock cycle: drive inputs, check outputs against the model,
  // advance the model, wait for the active edge.
  task automatic cycle(input logic v, input logic [3:0] m, input logic [31:0] d,
                       input logic ordy, input logic c);
    logic exp_rdy;
    logic exp_ov;
    logic acc;
    int   lim;
    int   np;
    @(negedge clk);
    in_valid  = v;
    in_mask   = m;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    #1;
    exp_rdy = !c && ((wq.size() < DEPTH) || ordy);
    exp_ov  = (wq.size() > 0) && (pq[0] == DEPTH - 1);
    chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    chk("q", q, q_m);
    rdy_seen = in_ready;
    if (c) begin
      model_reset();
    end else begin
      acc = v && exp_rdy;
      if (exp_ov && ordy) begin
        $display("[TB] pop  %h", wq[0]);
        void'(wq.pop_front());
        void'(pq.pop_front());
        n_pops++;
      end
      lim = DEPTH - 1;
      foreach (pq[i]) begin
        np = pq[i] + 1;
        if (np > lim) np = lim;
        pq[i] = np;
        if (np == DEPTH - 1) q_m = wq[i];
        lim = np - 1;
      end
      if (acc) begin
        acc_cnt++;
        for (int l = 0; l < LANES; l++) begin
          if (m[l]) base_m[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
        end
        wq.push_back(base_m);
        pq.push_back(0);
        if (DEPTH == 1) q_m = base_m;
        $display("[TB] push %h", base_m);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    int pops_before;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_mask   = 4'h0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_q", q, RV);
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);

    // Masked merge followed by a zero-mask beat
    cycle(1'b1, 4'hF, 32'h1122_3344, 1'b1, 1'b0);
    cycle(1'b1, 4'h2, 32'hFFFF_AAFF, 1'b1, 1'b0);
    #2 chk("merge_full", q, 32'h1122_3344);
    cycle(1'b1, 4'h0, 32'h5566_7788, 1'b1, 1'b0);
    #2 chk("merge_lane1", q, 32'h1122_AA44);
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    #2 chk("zero_mask_q", q, 32'h1122_AA44);
    chk("zero_mask_ov", {31'b0, out_valid}, 32'd1);
    idle(2);

    // Backpressure: only DEPTH beats fit, then drain in order
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'hF, 32'hB000_0001 + i, 1'b0, 1'b0);
      chk("bp_rdy", {31'b0, rdy_seen}, (i < 2) ? 32'd1 : 32'd0);
    end
    chk("bp_accepts", acc_cnt, 32'd2);
    pops_before = n_pops;
    idle(4);
    chk("bp_drained", n_pops - pops_before, 32'd2);

    // Clear priority over a full pipeline
    cycle(1'b1, 4'hF, 32'hC1C1_C1C1, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 32'hC2C2_C2C2, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("clr_rdy", {31'b0, rdy_seen}, 32'd0);
    #2 chk("clr_ov", {31'b0, out_valid}, 32'd0);
    chk("clr_q", q, RV);
    cycle(1'b1, 4'h1, 32'h0000_00CC, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    #2 chk("clr_base", q, 32'hA5A5_A5CC);
    idle(2);

    // Bubble collapse under a stalled consumer
    cycle(1'b1, 4'hF, 32'h0BB0_BB0B, 1'b0, 1'b0);
    #2 chk("bub_ov0", {31'b0, out_valid}, 32'd0);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #2 chk("bub_ov1", {31'b0, out_valid}, 32'd1);
    chk("bub_q", q, 32'h0BB0_BB0B);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #2 chk("bub_hold", q, 32'h0BB0_BB0B);
    idle(3);

    // Randomized traffic with an asynchronous reset mid-stream
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        #3 rst_n = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        #1;
        chk("arst_q", q, RV);
        chk("arst_ov", {31'b0, out_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle(($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            $urandom(),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 31) == 0));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
